// File: rtl/im_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// Latency: none (wires only).
// Backpressure: the producer holds in_valid/in_data while in_ready is low.
interface im_boot_loader_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  im_we;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [31:0]           im_wdata;
    logic                  cpu_rstn;
    logic                  done;
    logic                  err;
    logic [15:0]           words_loaded;

    // Host / stream producer side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rstn, done, err, words_loaded
    );

    // Loader side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_rstn, done, err, words_loaded
    );
endinterface

// File: rtl/im_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory; holds the CPU in reset until it is verified.
// Latency: the 4th byte of a word accepted on edge k gives a one-cycle im_we in the cycle after edge k.
// Backpressure: in_ready is registered, high only while a length, data or checksum byte is expected.
module im_boot_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int MAX_WORDS  = 128   // must not exceed 2**ADDR_WIDTH
) (
    input logic            i_clk,
    input logic            i_rst,
    im_boot_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_im_we;
    logic [ADDR_WIDTH-1:0] r_im_addr;
    logic [31:0]           r_im_wdata;
    logic                  r_cpu_rstn;
    logic                  r_done;
    logic                  r_err;
    logic [15:0]           r_words_loaded;
    logic [15:0]           r_count;       // image length in words
    logic [15:0]           r_index;       // next word address to write
    logic [1:0]            r_byte_idx;    // byte position within the current word
    logic [23:0]           r_word;        // first three bytes of the word in flight
    logic [7:0]            r_csum;        // running XOR of data bytes

    logic                  w_accept;
    logic [15:0]           w_len;
    logic [31:0]           w_word;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_len    = {r_count[15:8], bus.in_data};
    assign w_word   = {r_word, bus.in_data};

    // Load sequencer: all outputs are registered alongside the state so they change only on clock edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b0;
            r_im_we        <= 1'b0;
            r_im_addr      <= '0;
            r_im_wdata     <= '0;
            r_cpu_rstn     <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_words_loaded <= '0;
            r_count        <= '0;
            r_index        <= '0;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_csum         <= '0;
        end else begin
            r_im_we <= 1'b0;
            unique case (r_state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (bus.start) begin
                        r_state        <= S_LEN_HI;
                        r_in_ready     <= 1'b1;
                        r_cpu_rstn     <= 1'b0;
                        r_done         <= 1'b0;
                        r_err          <= 1'b0;
                        r_words_loaded <= '0;
                        r_index        <= '0;
                        r_csum         <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= bus.in_data;
                        r_state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= bus.in_data;
                        r_byte_idx   <= '0;
                        if (w_len > MAX_WORDS_W) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= w_word[23:0];
                        r_csum     <= r_csum ^ bus.in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Fourth byte completes the word: present it on the IM port for exactly one cycle.
                        if (r_byte_idx == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_im_we    <= 1'b1;
                            r_im_addr  <= r_index[ADDR_WIDTH-1:0];
                            r_im_wdata <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    r_index        <= r_index + 16'd1;
                    r_words_loaded <= r_words_loaded + 16'd1;
                    r_in_ready     <= 1'b1;
                    r_state        <= (r_index + 16'd1 == r_count) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state    <= S_RUN;
                            r_cpu_rstn <= 1'b1;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.im_we        = r_im_we;
    assign bus.im_addr      = r_im_addr;
    assign bus.im_wdata     = r_im_wdata;
    assign bus.cpu_rstn     = r_cpu_rstn;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.words_loaded = r_words_loaded;

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Synthesizable loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Receives a program image as a byte stream over a valid/ready handshake, assembles 32-bit words, and writes them into instruction ROM.
- Holds the CPU in reset (active-low cpu_rstn) until the whole image is loaded and its checksum verified.
- Replaces the simulation-only file preload with a hardware path usable on board.

Parameters:
- ADDR_WIDTH, 7, instruction-memory word-address width (128 words).
- MAX_WORDS, 128, largest image accepted; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse: begin a new load; honoured only in IDLE, RUN, ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_WIDTH  word address of the write.
- im_wdata  out  32  instruction word.
- cpu_rstn  out  1  CPU reset, active-low; 1 only in RUN.
- done  out  1  image loaded and verified (level).
- err  out  1  load failed (level).
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rstn=0, done=0, err=0, words_loaded=0, internal count/index/checksum cleared.
- Byte transfer occurs only on a rising edge with in_valid=1 and in_ready=1. in_ready is a registered function of state: 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 elsewhere.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N*4 data bytes (each word big-endian, MSB first), then 1 checksum byte.
- Checksum: XOR of every data byte, excluding the length bytes.
- IDLE: on start -> LEN_HI; clear words_loaded, index, checksum.
- LEN_HI: accept byte -> count[15:8]; -> LEN_LO.
- LEN_LO: accept byte -> count[7:0].
  - If assembled N > MAX_WORDS -> ERR.
  - If N == 0 -> CSUM (expected checksum 0x00).
  - Otherwise -> DATA with byte_idx=0.
- DATA: accept byte, shift it into word register, XOR it into checksum, byte_idx++. On the 4th byte (byte_idx wraps 3->0) -> WRITE.
- WRITE (exactly 1 cycle, in_ready=0):
  - im_we=1, im_addr=index[ADDR_WIDTH-1:0], im_wdata=assembled word.
  - Next edge: index++, words_loaded++.
  - -> CSUM if index+1 == N, else DATA.
  - im_we is high only during WRITE.
- Latency: the 4th byte accepted on edge k produces im_we=1 in the cycle after edge k.
- CSUM: accept byte. Equal to running checksum -> RUN; not equal -> ERR.
- RUN: cpu_rstn=1, done=1. On start -> LEN_HI, with cpu_rstn=0 and done=0 from the next edge; IM may be overwritten.
- ERR: err=1, cpu_rstn=0. Remains until start (-> LEN_HI, err cleared) or rst.
- start in LEN_HI/LEN_LO/DATA/WRITE/CSUM is ignored.
- in_valid with in_ready=0: byte is not consumed; the producer holds it.
- rst mid-load: immediate return to IDLE with cpu_rstn=0. Partially written IM contents are not cleared.
- IM contents beyond N are untouched.
- words_loaded holds its final value in RUN and ERR until the next start.

Test Plan:
- Load N=2: bytes 00 02 | 20 08 00 05 | 01 09 48 20 | checksum (XOR of the 8 data bytes) -> writes addr0=0x20080005 and addr1=0x01094820; in RUN: done=1, cpu_rstn=1, words_loaded=2.
- Same image with checksum byte ^0x01 -> both IM writes still occur; err=1, cpu_rstn=0, done=0.
- Length 0x0081 with MAX_WORDS=128 -> ERR right after LEN_LO; no im_we pulses; err=1.
- N=1 with in_valid toggled 1/0 every cycle, and in_valid held high during WRITE -> no byte lost or duplicated; im_we asserted one cycle after the 4th accepted byte; data correct.
- Assert rst during DATA after 5 bytes -> all outputs at reset values; a following start plus a full N=1 frame loads correctly to RUN.
- From RUN, pulse start and send N=1 image 0x00000000 -> cpu_rstn falls the next cycle; addr0 rewritten to 0x00000000; returns to RUN with words_loaded=1.
